// File: rtl/pc_sequencer.sv
// Program counter sequencer: starts one of three programs and steps the fetch address.
// Handles stall, halt, relative branch and a retired-instruction count.
module pc_sequencer #(
   parameter int unsigned     D        = 12,
   parameter logic [D-1:0]    P1_START = 12'd0,
   parameter logic [D-1:0]    P2_START = 12'd256,
   parameter logic [D-1:0]    P3_START = 12'd512
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    prog_sel,
   input  logic          stall,
   input  logic          halt_req,
   input  logic          branch_taken,
   input  logic [D-1:0]  offset,
   output logic [D-1:0]  prog_ctr,
   output logic          fetch_en,
   output logic          busy,
   output logic          done,
   output logic          sel_err,
   output logic [15:0]   instr_count
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          sel_valid;
   logic [D-1:0]  start_addr;
   logic [15:0]   cnt_inc;

   always_comb begin
      sel_valid  = 1'b1;
      start_addr = P1_START;
      case (prog_sel)
         2'b00:   start_addr = P1_START;
         2'b01:   start_addr = P2_START;
         2'b10:   start_addr = P3_START;
         default: sel_valid  = 1'b0;
      endcase
   end

   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (sel_valid) begin
                  state_d = StRun;
                  pc_d    = start_addr;
                  cnt_d   = 16'd0;
                  err_d   = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            // Stall freezes everything; halt/branch only act on a retiring cycle.
            if (!stall) begin
               cnt_d = cnt_inc;
               if (halt_req) begin
                  state_d = StDone;
               end else if (branch_taken) begin
                  pc_d = pc_q + offset;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign prog_ctr    = pc_q;
   assign instr_count = cnt_q;
   assign sel_err     = err_q;
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign fetch_en    = (state_q == StRun) & ~stall;

endmodule
